// File: rtl/toggle_cover_detect.sv
// Per-bit toggle detector: one registered valid pulse per bit on its first full
// 0->1 / 1->0 toggle, plus a running count of fully toggled bits.

module toggle_cover_lane (
    input  logic clock,
    input  logic clr_i,
    input  logic prime_i,
    input  logic armed_i,
    input  logic rec_i,
    input  logic sig_i,
    output logic full_new_o
);
    logic prev_q, rise_q, fall_q, done_q;
    logic rise_now, fall_now;

    assign rise_now   = ~prev_q & sig_i;
    assign fall_now   = prev_q & ~sig_i;
    assign full_new_o = rec_i & (rise_q | rise_now) & (fall_q | fall_now) & ~done_q;

    always_ff @(posedge clock) begin
        if (clr_i) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            done_q <= 1'b0;
        end else if (prime_i) begin
            prev_q <= sig_i;
        end else if (armed_i) begin
            // prev follows sig even when disabled, so disabled edges are lost
            prev_q <= sig_i;
            if (rec_i) begin
                rise_q <= rise_q | rise_now;
                fall_q <= fall_q | fall_now;
                done_q <= done_q | full_new_o;
            end
        end
    end
endmodule

module toggle_cover_detect #(
    parameter  int WIDTH = 34,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sig,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] valid,
    output logic [CNT_W-1:0] covered_cnt,
    output logic             all_covered
);
    typedef enum logic {PRIME, ARMED} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   valid_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d, pop;
    logic               all_q;
    logic [WIDTH-1:0]   full_new;
    logic               clr, prime, armed, rec;

    assign clr   = ~reset | clear;
    assign prime = (state_q == PRIME) & enable;
    assign armed = (state_q == ARMED);
    assign rec   = armed & enable;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        toggle_cover_lane u_lane (
            .clock     (clock),
            .clr_i     (clr),
            .prime_i   (prime),
            .armed_i   (armed),
            .rec_i     (rec),
            .sig_i     (sig[g]),
            .full_new_o(full_new[g])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + CNT_W'(full_new[i]);
    end

    assign cnt_d = cnt_q + pop;

    always_ff @(posedge clock) begin
        if (clr) begin
            state_q <= PRIME;
            valid_q <= '0;
            cnt_q   <= '0;
            all_q   <= 1'b0;
        end else begin
            valid_q <= full_new;
            cnt_q   <= cnt_d;
            all_q   <= (cnt_d == CNT_W'(WIDTH));
            if (prime) state_q <= ARMED;
        end
    end

    assign valid       = valid_q;
    assign covered_cnt = cnt_q;
    assign all_covered = all_q;
endmodule
